// File: rtl/sv12_lrm_p0816_b_dly_sched.sv
// Sequenced delay-selection controller: scans a programmable table of conditional
// A->Y path delays one entry per clock and returns the minimum matching rise/fall.
module sv12_lrm_p0816_b_dly_sched #(
    parameter int N_ENT     = 5,
    parameter int MW        = 3,
    parameter int DW        = 8,
    parameter int DFLT_RISE = 6,
    parameter int DFLT_FALL = 9,
    parameter int IW        = $clog2(N_ENT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic          cfg_en,
    input  logic [MW-1:0] cfg_mask,
    input  logic [DW-1:0] cfg_rise,
    input  logic [DW-1:0] cfg_fall,
    input  logic          req_valid,
    input  logic [MW-1:0] req_mode,
    output logic          req_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rise,
    output logic [DW-1:0] rsp_fall,
    output logic [N_ENT-1:0] rsp_hits,
    output logic          rsp_cond,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state_q, state_d;

    logic          en_q   [N_ENT];
    logic [MW-1:0] mask_q [N_ENT];
    logic [DW-1:0] rise_q [N_ENT];
    logic [DW-1:0] fall_q [N_ENT];

    logic [MW-1:0]    mode_q;
    logic [DW-1:0]    acc_rise_q, acc_fall_q;
    logic [N_ENT-1:0] hits_q;
    logic [IW-1:0]    idx_q;

    logic             last_ent;
    logic             cur_hit;
    logic [DW-1:0]    cur_rise, cur_fall;
    logic [DW-1:0]    rise_fold, fall_fold;
    logic [N_ENT-1:0] hits_fold;

    function automatic logic [MW-1:0] rst_mask(input int i);
        case (i)
            0: return MW'(5);
            1: return MW'(4);
            2: return MW'(3);
            3: return MW'(2);
            4: return MW'(1);
            default: return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] rst_rise(input int i);
        case (i)
            0: return DW'(5);
            1: return DW'(4);
            2: return DW'(6);
            3: return DW'(3);
            4: return DW'(7);
            default: return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] rst_fall(input int i);
        case (i)
            0: return DW'(9);
            1: return DW'(8);
            2: return DW'(5);
            3: return DW'(2);
            4: return DW'(7);
            default: return '0;
        endcase
    endfunction

    // NOTE: the table is a small register file, not a RAM, so it takes the async
    // reset; a reset must reload the default delays, not just clear control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) begin
                en_q[i]   <= (i < 5);
                mask_q[i] <= rst_mask(i);
                rise_q[i] <= rst_rise(i);
                fall_q[i] <= rst_fall(i);
            end
        end else if (cfg_we && int'(cfg_idx) < N_ENT) begin
            en_q[cfg_idx]   <= cfg_en;
            mask_q[cfg_idx] <= cfg_mask;
            rise_q[cfg_idx] <= cfg_rise;
            fall_q[cfg_idx] <= cfg_fall;
        end
    end

    // NOTE: every signal gets a default before the case/loop so no latch is inferred.
    always_comb begin
        cur_hit   = 1'b0;
        cur_rise  = '0;
        cur_fall  = '0;
        hits_fold = hits_q;
        for (int i = 0; i < N_ENT; i++) begin
            if (idx_q == IW'(i)) begin
                cur_hit      = en_q[i] && ((mode_q & mask_q[i]) != '0);
                cur_rise     = rise_q[i];
                cur_fall     = fall_q[i];
                hits_fold[i] = hits_q[i] | cur_hit;
            end
        end
        rise_fold = (cur_hit && cur_rise < acc_rise_q) ? cur_rise : acc_rise_q;
        fall_fold = (cur_hit && cur_fall < acc_fall_q) ? cur_fall : acc_fall_q;
        last_ent  = (state_q == SCAN) && (idx_q == IW'(N_ENT - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = SCAN;
            SCAN:    if (last_ent)  state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= '0;
            acc_rise_q <= '0;
            acc_fall_q <= '0;
            hits_q     <= '0;
            idx_q      <= '0;
            rsp_valid  <= 1'b0;
            rsp_rise   <= '0;
            rsp_fall   <= '0;
            rsp_hits   <= '0;
            rsp_cond   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    mode_q     <= req_mode;
                    acc_rise_q <= '1;
                    acc_fall_q <= '1;
                    hits_q     <= '0;
                    idx_q      <= '0;
                end
                SCAN: begin
                    acc_rise_q <= rise_fold;
                    acc_fall_q <= fall_fold;
                    hits_q     <= hits_fold;
                    idx_q      <= idx_q + 1'b1;
                    if (last_ent) begin
                        rsp_valid <= 1'b1;
                        rsp_hits  <= hits_fold;
                        rsp_cond  <= |hits_fold;
                        rsp_rise  <= (|hits_fold) ? rise_fold : DW'(DFLT_RISE);
                        rsp_fall  <= (|hits_fold) ? fall_fold : DW'(DFLT_FALL);
                    end
                end
                DONE: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sv12_lrm_p0816_b_dly_sched.md
# sv12_lrm_p0816_b_dly_sched

Sequenced delay-selection controller for a two-input/one-output cell whose A->Y path carries several state-dependent delays. It holds a programmable table of conditional path-delay entries (mode mask plus rise/fall delay) and, for each requested MODE value, scans the table one entry per clock. It returns the effective rise and fall delays: the smallest among all enabled entries whose condition `MODE & mask` is non-zero, or the unconditional default when no entry matches. It sits between mode-configuration logic and the timing-annotation consumer.

## Interface
- `N_ENT`, default 5: number of conditional entries; legal range 5..8.
- `MW`, default 3: MODE / mask width; legal range 3..8.
- `DW`, default 8: delay value width.
- `DFLT_RISE`, default 6: unconditional A->Y rise delay.
- `DFLT_FALL`, default 9: unconditional A->Y fall delay.
- `IW`, default $clog2(N_ENT): entry index width (derived, not overridden).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_we`  in  1  table write strobe.
- `cfg_idx`  in  IW  entry written.
- `cfg_en`  in  1  entry enable.
- `cfg_mask`  in  MW  condition mask.
- `cfg_rise`, `cfg_fall`  in  DW each  entry delays.
- `req_valid`  in  1  mode request valid.
- `req_mode`  in  MW  MODE value.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result consumed.
- `rsp_rise`, `rsp_fall`  out  DW each  effective delays.
- `rsp_hits`  out  N_ENT  bit i set when entry i matched.
- `rsp_cond`  out  1  at least one entry matched (0 means defaults were used).
- `busy`  out  1  state is not IDLE.

## Operation
- Entry i matches when `en[i]` is 1 and `(mode & mask[i]) != 0`.
- Rise and fall are minimised independently, so a result may take its rise from one entry and its fall from another.
- Reset table:
  - Entry 0: mask 5, delays (5,9).
  - Entry 1: mask 4, delays (4,8).
  - Entry 2: mask 3, delays (6,5).
  - Entry 3: mask 2, delays (3,2).
  - Entry 4: mask 1, delays (7,7).
  - Entries 0..4 are enabled. Entries 5 and above reset to disabled, mask 0, delays 0.
- Table writes:
  - A write takes effect on the edge where `cfg_we` is 1.
  - A write with `cfg_idx >= N_ENT` is dropped.
  - Writes are allowed in any state. An entry scanned on the same edge it is written uses its pre-write value.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: `req_ready`=1. When `req_valid` is high, capture `req_mode`, preset the rise and fall accumulators to all-ones, clear hits, set scan index to 0, and go to SCAN.
  - SCAN: evaluate entry `idx` each edge and fold it into the accumulators and hits. On `idx == N_ENT-1`, go to DONE and register the outputs. If no entry hit, output `DFLT_RISE`/`DFLT_FALL`; otherwise output the accumulators.
  - DONE: `rsp_valid`=1 with outputs held stable. On `rsp_ready`, go to IDLE.
- `req_valid` outside IDLE is ignored, and `req_ready` stays 0.
- Comparisons are unsigned DW-bit. A delay of 0 is legal and wins any minimum.
- Reset values: state IDLE, `req_ready`=1 (combinational from state), `rsp_valid`=0, `rsp_rise`=0, `rsp_fall`=0, `rsp_hits`=0, `rsp_cond`=0, `busy`=0.
- Reset asserted mid-SCAN or in DONE immediately aborts the operation, drops the result and reloads the reset table.

## Timing
- Request accepted at edge E0. Entries are evaluated at edges E0+1 .. E0+N_ENT.
- `rsp_valid` is high from edge E0+N_ENT, which is 5 clocks for the default N_ENT.
- Earliest next acceptance is edge Ed+1, where Ed is the edge on which `rsp_valid && rsp_ready` held. Maximum throughput is one result per N_ENT+2 clocks.
- `rsp_*` remain stable while `rsp_valid` is high and `rsp_ready` is low, for an unbounded stall.
- All outputs are registered except `req_ready` and `busy`, which decode the state register.

## Test plan
- Reset, then request MODE=3 with `rsp_ready`=1. Required: `rsp_hits`=5'b11101, rise=3, fall=2, `rsp_cond`=1, and `rsp_valid` exactly 5 clocks after acceptance.
- Request MODE=4. Required: hits=5'b00011, rise=4, fall=8. Then request MODE=0. Required: hits=0, `rsp_cond`=0, rise=6, fall=9.
- Write entry 3 with en=0, then request MODE=2. Required: hits=5'b00100, rise=6, fall=5.
- Hold `rsp_ready`=0 for 10 clocks with `req_valid` held high and a different mode. Required: result held stable, `req_ready`=0, and the second request accepted only after the response handshake.
- Write entry 2 with mask 7, delays (1,1) on the same edge the scan evaluates entry 2, using MODE=3. Required: old values used (rise=3, fall=2). A repeat request returns rise=1, fall=1.
- Assert `rst` in the third SCAN cycle. Required: `rsp_valid` never rises, `busy`=0, and after reset MODE=3 again returns (3,2).
